// File: rtl/icache_fill_controller.sv
// icache_fill_controller
// Multi-line instruction cache fill controller between the program sequencer
// and program ROM. Hits select a cache line combinationally. A miss holds the
// sequencer while a full 32-word ROM block is streamed into a round-robin
// victim line, then the line's tag is installed and hold is released.
// Optional build macro: ICACHE_PERF_CNT_EN enables saturating hit/miss
// performance counters; without it both counter ports read zero.
module icache_fill_controller #(
    parameter int NUM_LINES   = 2,
    parameter int LINE_IDX_W  = 1,
    parameter int ROM_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_valid,
    input  logic [7:0]            req_addr,
    input  logic                  flush,
    output logic                  hold,
    output logic [7:0]            rom_address,
    output logic                  cache_wren,
    output logic [LINE_IDX_W-1:0] cache_wrline,
    output logic [4:0]            cache_wroffset,
    output logic [LINE_IDX_W-1:0] cache_rdline,
    output logic [4:0]            cache_rdoffset,
    output logic [15:0]           hit_count,
    output logic [15:0]           miss_count
);

    typedef enum logic {IDLE, FILL} state_t;

    state_t                state_reg, state_next;
    logic [NUM_LINES-1:0]  valid_reg;
    logic [2:0]            tag_reg [NUM_LINES];
    logic [LINE_IDX_W-1:0] victim_reg;
    logic [LINE_IDX_W-1:0] fill_line_reg;
    logic [2:0]            fill_tag_reg;
    logic [5:0]            issue_cnt_reg;
    logic                  flush_pend_reg;
    logic                  pipe_vld_reg [ROM_LATENCY];
    logic [4:0]            pipe_off_reg [ROM_LATENCY];

    logic [NUM_LINES-1:0]  match;
    logic                  hit;
    logic [LINE_IDX_W-1:0] hit_line;
    logic                  miss;
    logic                  wr_last;
    logic                  fill_done;
    logic                  issue_valid;
    logic [4:0]            issue_off;

    // Per-line tag comparison against the incoming fetch tag
    generate
        for (genvar gi = 0; gi < NUM_LINES; gi++) begin : g_match
            assign match[gi] = valid_reg[gi] && (tag_reg[gi] == req_addr[7:5]);
        end
    endgenerate

    // Priority-select the lowest-index matching line
    always_comb begin
        hit      = 1'b0;
        hit_line = '0;
        for (int i = NUM_LINES - 1; i >= 0; i--) begin
            if (match[i]) begin
                hit      = 1'b1;
                hit_line = LINE_IDX_W'(i);
            end
        end
    end

    assign miss      = (state_reg == IDLE) && req_valid && !hit;
    assign wr_last   = pipe_vld_reg[ROM_LATENCY-1] && (pipe_off_reg[ROM_LATENCY-1] == 5'd31);
    assign fill_done = (state_reg == FILL) && wr_last;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_reg <= IDLE;
        else          state_reg <= state_next;
    end

    // Next-state: leave IDLE on a miss, return once offset 31 is written
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (miss)      state_next = FILL;
            FILL:    if (fill_done) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    // Outputs: hold, ROM address and the offset entering the write pipeline
    always_comb begin
        hold        = 1'b0;
        rom_address = {req_addr[7:5], 5'd0};
        issue_valid = 1'b0;
        issue_off   = 5'd0;
        case (state_reg)
            IDLE: begin
                hold        = miss;
                issue_valid = miss;
            end
            FILL: begin
                hold        = 1'b1;
                issue_valid = !issue_cnt_reg[5];
                issue_off   = issue_cnt_reg[5] ? 5'd31 : issue_cnt_reg[4:0];
                rom_address = {fill_tag_reg, issue_off};
            end
            default: ;
        endcase
    end

    // Fill context: latched at miss, issue counter stops at 32
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fill_tag_reg   <= 3'd0;
            fill_line_reg  <= '0;
            issue_cnt_reg  <= 6'd0;
            flush_pend_reg <= 1'b0;
            victim_reg     <= '0;
        end else if (miss) begin
            fill_tag_reg   <= req_addr[7:5];
            fill_line_reg  <= victim_reg;
            issue_cnt_reg  <= 6'd1;
            flush_pend_reg <= 1'b0;
        end else if (state_reg == FILL) begin
            if (!issue_cnt_reg[5]) issue_cnt_reg <= issue_cnt_reg + 6'd1;
            if (flush)             flush_pend_reg <= 1'b1;
            if (fill_done) begin
                flush_pend_reg <= 1'b0;
                victim_reg     <= (victim_reg == LINE_IDX_W'(NUM_LINES - 1)) ? '0
                                  : victim_reg + LINE_IDX_W'(1);
            end
        end
    end

    // Write pipeline: delays each issued offset by the ROM read latency
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < ROM_LATENCY; i++) begin
                pipe_vld_reg[i] <= 1'b0;
                pipe_off_reg[i] <= 5'd0;
            end
        end else begin
            pipe_vld_reg[0] <= issue_valid;
            pipe_off_reg[0] <= issue_off;
            for (int i = 1; i < ROM_LATENCY; i++) begin
                pipe_vld_reg[i] <= pipe_vld_reg[i-1];
                pipe_off_reg[i] <= pipe_off_reg[i-1];
            end
        end
    end

    // Line state: install tag at fill end, or wipe everything on a flush
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_reg <= '0;
            for (int i = 0; i < NUM_LINES; i++) tag_reg[i] <= 3'd0;
        end else if (fill_done) begin
            if (flush_pend_reg || flush) begin
                valid_reg <= '0;
            end else begin
                valid_reg[fill_line_reg] <= 1'b1;
                tag_reg[fill_line_reg]   <= fill_tag_reg;
            end
        end else if ((state_reg == IDLE) && flush) begin
            valid_reg <= '0;
        end
    end

    assign cache_wren     = pipe_vld_reg[ROM_LATENCY-1];
    assign cache_wroffset = pipe_off_reg[ROM_LATENCY-1];
    assign cache_wrline   = fill_line_reg;
    assign cache_rdline   = hit_line;
    assign cache_rdoffset = req_addr[4:0];

`ifdef ICACHE_PERF_CNT_EN
    logic [15:0] hit_cnt_reg;
    logic [15:0] miss_cnt_reg;

    // Saturating performance counters, cleared by reset only
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hit_cnt_reg  <= 16'd0;
            miss_cnt_reg <= 16'd0;
        end else begin
            if ((state_reg == IDLE) && req_valid && hit && (hit_cnt_reg != 16'hFFFF))
                hit_cnt_reg <= hit_cnt_reg + 16'd1;
            if (miss && (miss_cnt_reg != 16'hFFFF))
                miss_cnt_reg <= miss_cnt_reg + 16'd1;
        end
    end

    assign hit_count  = hit_cnt_reg;
    assign miss_count = miss_cnt_reg;
`else
    assign hit_count  = 16'd0;
    assign miss_count = 16'd0;
`endif

endmodule

// File: doc/icache_fill_controller.md
Name: icache_fill_controller

Overview:
- Controller for a multi-line instruction cache placed between the program sequencer and program ROM.
- Each cycle it checks the sequencer's fetch address against per-line tags. On a hit it selects the cache line to read.
- On a miss it asserts hold to the sequencer, fetches the full 32-word ROM block, writes it into a victim line, updates that line's tag, then releases hold.
- Generalises the single-line hold/refill scheme to NUM_LINES lines with round-robin replacement and a parameterised ROM read latency.

Parameters:
- NUM_LINES, 2: number of cache lines; power of two, 1..8.
- LINE_IDX_W, 1: log2(NUM_LINES), minimum 1.
- ROM_LATENCY, 1: clocks from rom_address to valid rom data; 1..4.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  1  sequencer fetch address valid this cycle.
- req_addr  in  8  fetch address; [7:5] tag, [4:0] word offset.
- flush  in  1  invalidate all lines (single-cycle pulse).
- hold  out  1  stall request to sequencer (pc must not advance).
- rom_address  out  8  program ROM read address.
- cache_wren  out  1  cache write strobe, aligned with rom data.
- cache_wrline  out  LINE_IDX_W  line being written.
- cache_wroffset  out  5  word offset being written.
- cache_rdline  out  LINE_IDX_W  line holding req_addr tag (valid only on a hit).
- cache_rdoffset  out  5  equals req_addr[4:0], combinational.
- hit_count  out  16  perf counter (see Optional Feature).
- miss_count  out  16  perf counter (see Optional Feature).

Behaviour:
- Reset (reset_n=0, async):
  - state=IDLE; all valid bits=0; tags=0; victim pointer=0; issue counter=0; write pipeline cleared.
  - Outputs: hold=0, cache_wren=0, cache_wrline=0, cache_wroffset=0, cache_rdline=0, rom_address=0, counters=0.
- Hit: in IDLE, req_valid=1 and some line has valid=1 with tag==req_addr[7:5].
  - cache_rdline = lowest-index matching line, combinational; hold=0.
- Miss: in IDLE, req_valid=1 and no valid match.
  - hold=1 combinationally in the same cycle (c0).
  - rom_address={req_addr[7:5],5'd0} in c0.
  - Latch fill_tag=req_addr[7:5] and fill_line=victim pointer; next state FILL; issue counter=1.
- In IDLE with no miss, rom_address={req_addr[7:5],5'd0} (prefetch-neutral; not written).
- FILL state:
  - hold=1.
  - rom_address={fill_tag, issue_cnt} while issue_cnt<=31; issue_cnt increments each cycle.
  - After offset 31 has been issued, rom_address holds {fill_tag,5'd31}.
- Write pipeline: each issued offset is delayed ROM_LATENCY cycles.
  - Offset k is written at cycle c(k+ROM_LATENCY) with cache_wren=1, cache_wrline=fill_line, cache_wroffset=k.
  - Exactly 32 writes per fill, offsets 0..31 in order, no gaps.
- Fill completion: on the edge that writes offset 31:
  - tag[fill_line]=fill_tag and valid[fill_line]=1.
  - Victim pointer increments modulo NUM_LINES; state returns to IDLE.
- Hold timing: hold is high for cycles c0..c(31+ROM_LATENCY) inclusive, i.e. 32+ROM_LATENCY cycles. In the following cycle the request hits and hold=0.
- cache_wren=0 at all times outside the 32 write cycles.
- req_addr changes during FILL are ignored; fill_tag is fixed for the whole fill.
- flush in IDLE: all valid bits cleared at that edge. A same-cycle miss still starts normally.
- flush during FILL: latched as pending. At fill completion all valid bits (including fill_line) are cleared instead of setting valid, so the next IDLE cycle misses again. Victim pointer still advances.
- reset_n asserted mid-fill: fill is abandoned immediately; no line is marked valid.
- Widths: the issue counter is 6 bits so it can stop at 32; all offsets truncate to 5 bits.

Optional Feature:
- Macro ICACHE_PERF_CNT_EN.
- Defined:
  - hit_count increments once per IDLE cycle with req_valid=1 and a hit.
  - miss_count increments once per fill start.
  - Both saturate at 16'hFFFF, and both are cleared by reset only, not by flush.
- Undefined: the counter logic is not built and both ports are tied to 16'd0.

Test Plan:
- Cold start, ROM_LATENCY=1, req_addr=8'h00 → hold high 33 cycles; rom_address 8'h00..8'h1F on consecutive cycles; 32 writes (line 0, offsets 0..31) starting one cycle after the miss; then hold=0 and cache_rdline=0.
- Sequential fetch 8'h00→8'h20→8'h05 → second miss fills line 1 with tag 1; 8'h05 then hits line 0 with no hold.
- Third distinct block 8'h40 with NUM_LINES=2 → victim is line 0 (round-robin); a later fetch of 8'h03 misses and refills line 1.
- flush asserted in FILL cycle 10 of a fill for 8'h60 → fill completes all 32 writes; next cycle req 8'h60 misses again; all valid bits are 0.
- reset_n pulsed low at fill cycle 15 → hold=0 and cache_wren=0 immediately; after release, a request for the same address misses.
- ICACHE_PERF_CNT_EN defined, run 1 miss plus 40 hit cycles → miss_count=1, hit_count=40. Undefined → both read 0.
